game_hub: RTL and testbench
===========================

GAME_HUB -- requirements
Module: game_hub

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, stable-input cycles needed to accept a key level (20 ms at 50 MHz).
REQ-002 Parameter: IDLE_TIMEOUT, default 1500000000, PLAYING cycles with no score_in change before forced SUMMARY (30 s).
REQ-003 Port: CLOCK_50  in  1  system clock, 50 MHz, all logic on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-high; clears all state.
REQ-005 Port: KEY  in  4  pushbuttons, active-low, asynchronous to CLOCK_50; KEY[0]=start/continue, KEY[3]=quit; KEY[2:1] unused.
REQ-006 Port: score_in  in  11  game-reported score, unsigned 0..2047, sampled every cycle.
REQ-007 Port: toggle  out  1  game enable; 1 only in PLAYING.
REQ-008 Port: LEDG  out  8  LEDG[2:0] one-hot state (bit0 MENU, bit1 PLAYING, bit2 SUMMARY); LEDG[7:3]=0.
REQ-009 Port: HEX7..HEX0  out  7 each  active-low 7-segment digits; HEX7..HEX4 session score, HEX3..HEX0 best score, decimal, MSD leftmost.

Function
REQ-010 Keys SHALL pass a 2-flop synchronizer; a press event SHALL be one cycle on the 1->0 transition of the accepted level, one event per press regardless of hold time.
REQ-011 States SHALL be MENU, PLAYING, SUMMARY, 2-bit encoded.
REQ-012 MENU: toggle=0; KEY[0] event -> PLAYING, session cleared to 0 in the same cycle.
REQ-013 PLAYING: toggle=1; each cycle, if score_in > session then session<=score_in; if score_in > best then best<=score_in.
REQ-014 PLAYING: KEY[3] event -> SUMMARY; KEY[0] events ignored; KEY[3] wins on a simultaneous event.
REQ-015 PLAYING: 31-bit idle counter cleared on entry and whenever score_in differs from its previous-cycle value; on reaching IDLE_TIMEOUT-1 -> SUMMARY next cycle.
REQ-016 SUMMARY: toggle=0; session and best frozen; KEY[0] event -> MENU; KEY[3] ignored.
REQ-017 toggle SHALL be registered and change on the same edge as the state register.
REQ-018 Each 11-bit score SHALL convert to 4 BCD digits (0000..2047) and then to segments: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 HEX outputs SHALL be registered, reflecting session/best exactly 1 cycle after they change.
REQ-020 Leading zeros SHALL be displayed (no blanking).
REQ-021 Score compare SHALL be unsigned 11-bit; equal values cause no update.

Reset
REQ-022 On reset assertion, without waiting for a clock edge: state=MENU, toggle=0, session=0, best=0, idle counter=0, debounce counters=0, LEDG=8'b00000001, all HEX=1000000.
REQ-023 Synchronizers SHALL reset to 1 (released); a key held low through reset release SHALL NOT produce an event until it is released and pressed again.
REQ-024 Reset during PLAYING SHALL drop toggle immediately and discard best.

Configuration
REQ-025 Macro GAME_HUB_DEBOUNCE_EN defined: a key level is accepted only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-026 GAME_HUB_DEBOUNCE_EN undefined: the synchronized level is accepted directly; no debounce counters exist; DEBOUNCE_CYCLES is unused.

Verification
REQ-027 Reset, then KEY[0] pulsed low -> PLAYING, toggle=1, LEDG=00000010, HEX7..HEX4 all 1000000.
REQ-028 In PLAYING, score_in 3 then 1234 then 900 -> session=1234, best=1234; HEX3..HEX0 = 1111001,0100100,0110000,0011001.
REQ-029 KEY[3] and KEY[0] pressed in same cycle during PLAYING -> SUMMARY, toggle=0 next cycle; second round with max score 5 -> best stays 1234, session 0005.
REQ-030 IDLE_TIMEOUT=100, score_in constant in PLAYING -> SUMMARY exactly 100 cycles after entry; score change at cycle 50 -> SUMMARY at cycle 150.
REQ-031 Macro defined, DEBOUNCE_CYCLES=8, KEY[0] bouncing with 5-cycle pulses then held low -> exactly one event; macro undefined, same stimulus -> first accepted event moves MENU->PLAYING.
REQ-032 Reset asserted mid-PLAYING with best=2047 -> toggle=0 without a clock edge, best=0, HEX3..HEX0 all 1000000.

Source files
------------

// File: rtl/game_hub.sv
// game_hub: menu / playing / summary controller for a score-reporting game.
// Two synchronized pushbuttons (KEY[0] start/continue, KEY[3] quit) drive the FSM.
// Session and best scores are tracked and shown as decimal on eight 7-segment digits.
// Optional key debouncing is enabled by defining GAME_HUB_DEBOUNCE_EN.
module game_hub #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int IDLE_TIMEOUT    = 1500000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  KEY,
  input  logic [10:0] score_in,
  output logic        toggle,
  output logic [7:0]  LEDG,
  output logic [6:0]  HEX7,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  typedef enum logic [1:0] {MENU = 2'd0, PLAYING = 2'd1, SUMMARY = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [10:0] session, best, score_prev;
  logic [30:0] idle_cnt;
  logic [1:0]  key_raw;
  logic [1:0]  key_ev;   // [0] start/continue, [1] quit
  logic        unused_cfg;

  assign key_raw = {KEY[3], KEY[0]};

`ifdef GAME_HUB_DEBOUNCE_EN
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  assign unused_cfg = ^KEY[2:1];
`else
  assign unused_cfg = ^KEY[2:1] ^ (DEBOUNCE_CYCLES != 0);
`endif

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0] sync_q;
    logic [1:0] flush;
    logic       lvl, lvl_q, armed;

    // two-flop synchronizer, idles released (high)
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], key_raw[k]};
    end

`ifdef GAME_HUB_DEBOUNCE_EN
    logic [DBW-1:0] cnt;
    // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (sync_q[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= sync_q[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + DBW'(1);
      end
    end
`else
    assign lvl = sync_q[1];
`endif

    // arm only once a real released level has been seen after reset, so a key
    // held through reset release cannot fire until it is released and pressed again
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        flush <= 2'b00;
        lvl_q <= 1'b1;
        armed <= 1'b0;
      end else begin
        flush <= {flush[0], 1'b1};
        lvl_q <= lvl;
        if (flush[1] && sync_q[1] && lvl) armed <= 1'b1;
      end
    end

    assign key_ev[k] = armed & lvl_q & ~lvl;
  end

  // next-state logic; quit takes priority over timeout and start
  always_comb begin
    state_d = state_q;
    case (state_q)
      MENU:    if (key_ev[0]) state_d = PLAYING;
      PLAYING: if (key_ev[1] || idle_cnt == 31'(IDLE_TIMEOUT - 1)) state_d = SUMMARY;
      SUMMARY: if (key_ev[0]) state_d = MENU;
      default: state_d = MENU;
    endcase
  end

  // state register and registered game enable
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= MENU;
      toggle  <= 1'b0;
    end else begin
      state_q <= state_d;
      toggle  <= (state_d == PLAYING);
    end
  end

  // score tracking and idle counter
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      session    <= '0;
      best       <= '0;
      score_prev <= '0;
      idle_cnt   <= '0;
    end else begin
      score_prev <= score_in;
      if (state_q == MENU && key_ev[0]) session <= '0;
      if (state_q == PLAYING) begin
        if (score_in > session) session <= score_in;
        if (score_in > best)    best    <= score_in;
        idle_cnt <= (score_in != score_prev) ? 31'd0 : idle_cnt + 31'd1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign LEDG = {5'b00000, state_q == SUMMARY, state_q == PLAYING, state_q == MENU};

  function automatic logic [15:0] to_bcd(input logic [10:0] b);
    logic [15:0] d;
    d = '0;
    for (int i = 10; i >= 0; i--) begin
      for (int j = 0; j < 4; j++)
        if (d[4*j +: 4] >= 4'd5) d[4*j +: 4] = d[4*j +: 4] + 4'd3;
      d = {d[14:0], b[i]};
    end
    return d;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  logic [15:0] s_bcd, b_bcd;
  assign s_bcd = to_bcd(session);
  assign b_bcd = to_bcd(best);

  // registered display, one cycle behind the score registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      {HEX7, HEX6, HEX5, HEX4} <= {4{7'b1000000}};
      {HEX3, HEX2, HEX1, HEX0} <= {4{7'b1000000}};
    end else begin
      {HEX7, HEX6, HEX5, HEX4} <= {seg(s_bcd[15:12]), seg(s_bcd[11:8]), seg(s_bcd[7:4]), seg(s_bcd[3:0])};
      {HEX3, HEX2, HEX1, HEX0} <= {seg(b_bcd[15:12]), seg(b_bcd[11:8]), seg(b_bcd[7:4]), seg(b_bcd[3:0])};
    end
  end

endmodule

// File: tb/tb_game_hub.sv
// Directed bench for game_hub (DEBOUNCE_CYCLES=8, IDLE_TIMEOUT=100).
module tb_game_hub;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [10:0] score_in = '0;
  logic        toggle;
  logic [7:0]  LEDG;
  logic [6:0]  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  int checks = 0;
  int failures = 0;

  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  game_hub #(.DEBOUNCE_CYCLES(8), .IDLE_TIMEOUT(100)) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(KEY), .score_in(score_in), .toggle(toggle), .LEDG(LEDG),
    .HEX7(HEX7), .HEX6(HEX6), .HEX5(HEX5), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0));

  always #5 clk = ~clk;

  function automatic logic [27:0] dig4(input int a, input int b, input int c, input int d);
    return {SEG[a], SEG[b], SEG[c], SEG[d]};
  endfunction

  task automatic press(input logic [3:0] mask);
    KEY = 4'hF & ~mask;
    repeat (14) @(negedge clk);
    KEY = 4'hF;
    repeat (14) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    KEY = 4'hF; score_in = '0;
    @(negedge clk); #2 reset = 1'b1; #1;
    checks++; if (LEDG !== 8'b00000001) begin failures++; $display("FAIL reset_ledg got=%b exp=%b", LEDG, 8'b00000001); end
    checks++; if (toggle !== 1'b0) begin failures++; $display("FAIL reset_toggle got=%b exp=0", toggle); end
    checks++; if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {dig4(0,0,0,0), dig4(0,0,0,0)})
      begin failures++; $display("FAIL reset_hex got=%h exp=%h", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {dig4(0,0,0,0), dig4(0,0,0,0)}); end
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // bouncing start key: three 5-cycle low pulses, then held low
  task automatic test_debounce();
    for (int p = 0; p < 3; p++) begin
      KEY[0] = 1'b0; repeat (5) @(negedge clk);
      KEY[0] = 1'b1; repeat (5) @(negedge clk);
    end
`ifdef GAME_HUB_DEBOUNCE_EN
    checks++; if (LEDG !== 8'b00000001) begin failures++; $display("FAIL debounce_bounce_ignored got=%b exp=%b", LEDG, 8'b00000001); end
`else
    checks++; if (LEDG !== 8'b00000010) begin failures++; $display("FAIL nodebounce_first_pulse got=%b exp=%b", LEDG, 8'b00000010); end
`endif
    KEY[0] = 1'b0; repeat (20) @(negedge clk);
    checks++; if (LEDG !== 8'b00000010) begin failures++; $display("FAIL debounce_held_accept got=%b exp=%b", LEDG, 8'b00000010); end
    KEY[0] = 1'b1;
    do_reset();
  endtask

  task automatic test_start();
    score_in = '0;
    press(4'b0001);
    checks++; if (LEDG !== 8'b00000010) begin failures++; $display("FAIL start_ledg got=%b exp=%b", LEDG, 8'b00000010); end
    checks++; if (toggle !== 1'b1) begin failures++; $display("FAIL start_toggle got=%b exp=1", toggle); end
    checks++; if ({HEX7, HEX6, HEX5, HEX4} !== dig4(0,0,0,0)) begin failures++; $display("FAIL start_session_hex got=%h exp=%h", {HEX7, HEX6, HEX5, HEX4}, dig4(0,0,0,0)); end
  endtask

  task automatic test_scores();
    score_in = 11'd3;    repeat (3) @(negedge clk);
    checks++; if ({HEX7, HEX6, HEX5, HEX4} !== dig4(0,0,0,3)) begin failures++; $display("FAIL score3_session got=%h exp=%h", {HEX7, HEX6, HEX5, HEX4}, dig4(0,0,0,3)); end
    score_in = 11'd1234; repeat (3) @(negedge clk);
    score_in = 11'd900;  repeat (3) @(negedge clk);
    checks++; if ({HEX7, HEX6, HEX5, HEX4} !== dig4(1,2,3,4)) begin failures++; $display("FAIL scores_session got=%h exp=%h", {HEX7, HEX6, HEX5, HEX4}, dig4(1,2,3,4)); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== dig4(1,2,3,4)) begin failures++; $display("FAIL scores_best got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, dig4(1,2,3,4)); end
  endtask

  task automatic test_quit_round();
    press(4'b1001);
    checks++; if (LEDG !== 8'b00000100) begin failures++; $display("FAIL quit_simul_ledg got=%b exp=%b", LEDG, 8'b00000100); end
    checks++; if (toggle !== 1'b0) begin failures++; $display("FAIL quit_toggle got=%b exp=0", toggle); end
    score_in = 11'd2000; repeat (3) @(negedge clk);
    checks++; if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {dig4(1,2,3,4), dig4(1,2,3,4)})
      begin failures++; $display("FAIL summary_frozen got=%h exp=%h", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {dig4(1,2,3,4), dig4(1,2,3,4)}); end
    press(4'b1000);
    checks++; if (LEDG !== 8'b00000100) begin failures++; $display("FAIL summary_quit_ignored got=%b exp=%b", LEDG, 8'b00000100); end
    score_in = '0;
    press(4'b0001);
    checks++; if (LEDG !== 8'b00000001) begin failures++; $display("FAIL summary_to_menu got=%b exp=%b", LEDG, 8'b00000001); end
    press(4'b0001);
    checks++; if ({HEX7, HEX6, HEX5, HEX4} !== dig4(0,0,0,0)) begin failures++; $display("FAIL round2_cleared got=%h exp=%h", {HEX7, HEX6, HEX5, HEX4}, dig4(0,0,0,0)); end
    score_in = 11'd5; repeat (3) @(negedge clk);
    score_in = 11'd2; repeat (3) @(negedge clk);
    press(4'b1000);
    checks++; if (LEDG !== 8'b00000100) begin failures++; $display("FAIL round2_quit got=%b exp=%b", LEDG, 8'b00000100); end
    checks++; if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {dig4(0,0,0,5), dig4(1,2,3,4)})
      begin failures++; $display("FAIL round2_scores got=%h exp=%h", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {dig4(0,0,0,5), dig4(1,2,3,4)}); end
  endtask

  // count cycles toggle stays high from entry; optional score change at cycle 50
  task automatic idle_run(input bit chg, input int exp_cycles);
    int w, cnt;
    press(4'b0001);
    score_in = 11'd7; repeat (3) @(negedge clk);
    KEY[0] = 1'b0; w = 0;
    while (toggle !== 1'b1 && w < 60) begin @(negedge clk); w++; end
    checks++; if (toggle !== 1'b1) begin failures++; $display("FAIL idle_entry_timeout got=%b exp=1", toggle); end
    cnt = 0;
    while (toggle === 1'b1 && cnt < 400) begin
      cnt++;
      if (cnt == 5) KEY[0] = 1'b1;
      if (chg && cnt == 50) score_in = 11'd8;
      @(negedge clk);
    end
    checks++; if (cnt != exp_cycles) begin failures++; $display("FAIL idle_cycles chg=%0d got=%0d exp=%0d", chg, cnt, exp_cycles); end
    checks++; if (LEDG !== 8'b00000100) begin failures++; $display("FAIL idle_summary got=%b exp=%b", LEDG, 8'b00000100); end
    KEY[0] = 1'b1; repeat (14) @(negedge clk);
  endtask

  task automatic test_idle();
    idle_run(1'b0, 100);
    idle_run(1'b1, 150);
  endtask

  task automatic test_reset_midplay();
    press(4'b0001);
    score_in = '0;
    press(4'b0001);
    score_in = 11'd2047; repeat (3) @(negedge clk);
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== dig4(2,0,4,7)) begin failures++; $display("FAIL best_2047 got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, dig4(2,0,4,7)); end
    @(posedge clk); #3 reset = 1'b1; #1;
    checks++; if (toggle !== 1'b0) begin failures++; $display("FAIL midplay_toggle got=%b exp=0", toggle); end
    checks++; if (LEDG !== 8'b00000001) begin failures++; $display("FAIL midplay_ledg got=%b exp=%b", LEDG, 8'b00000001); end
    checks++; if ({HEX3, HEX2, HEX1, HEX0} !== dig4(0,0,0,0)) begin failures++; $display("FAIL midplay_best got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, dig4(0,0,0,0)); end
    @(negedge clk); reset = 1'b0;
    score_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_key_held_reset();
    KEY[0] = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (LEDG !== 8'b00000001) begin failures++; $display("FAIL held_through_reset got=%b exp=%b", LEDG, 8'b00000001); end
    KEY[0] = 1'b1; repeat (20) @(negedge clk);
    checks++; if (LEDG !== 8'b00000001) begin failures++; $display("FAIL held_release got=%b exp=%b", LEDG, 8'b00000001); end
    press(4'b0001);
    checks++; if (LEDG !== 8'b00000010) begin failures++; $display("FAIL held_repress got=%b exp=%b", LEDG, 8'b00000010); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_start();
    test_scores();
    test_quit_round();
    test_idle();
    test_reset_midplay();
    test_key_held_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
